exit_park: RTL and testbench



---
 rtl/exit_park.sv | 132 +++++++++++++
 tb/tb_exit_park.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exit_park.sv
`default_nettype none
// ============================================================================
//  Module      : exit_park
//  Description : Exit-side parking controller. Validates a car-leaving
//                request against the shared occupancy map, pulses a one-hot
//                release mask for the occupancy owner, holds the exit gate
//                open for GATE_CYCLES cycles and counts successful exits.
//  Revision    : 1.0 - initial release
// ============================================================================
module exit_park #(
  parameter int GATE_CYCLES = 4          // gate-open duration, legal 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       exit_req,
  input  logic [2:0] exit_slot,
  input  logic [7:0] parking_capacity,
  output logic [7:0] release_mask,
  output logic       exit_ack,
  output logic       exit_err,
  output logic       gate_open,
  output logic       busy,
  output logic [7:0] exit_count
);

  localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_RELEASE  = 3'd2,
    S_GATE     = 3'd3,
    S_ERROR    = 3'd4,
    S_WAIT_LOW = 3'd5
  } state_t;

  state_t     state_q;
  logic [2:0] slot_q;
  logic [3:0] gate_cnt_q;
  logic [7:0] release_mask_q;
  logic       exit_ack_q;
  logic       exit_err_q;
  logic       gate_open_q;
  logic       busy_q;
  logic [7:0] exit_count_q;
  logic [7:0] exit_count_d;

  // Wrapping successor of the exit counter (255 -> 0 falls out naturally).
  assign exit_count_d = exit_count_q + 8'd1;

  // Controller FSM; every output is a flop loaded together with the state it
  // belongs to, so the outputs are glitch-free and aligned with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      slot_q         <= 3'd0;
      gate_cnt_q     <= 4'd0;
      release_mask_q <= 8'd0;
      exit_ack_q     <= 1'b0;
      exit_err_q     <= 1'b0;
      gate_open_q    <= 1'b0;
      busy_q         <= 1'b0;
      exit_count_q   <= 8'd0;
    end else begin
      // Pulse outputs default low; only the CHECK decision raises them.
      release_mask_q <= 8'd0;
      exit_ack_q     <= 1'b0;
      exit_err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (exit_req) begin
            slot_q  <= exit_slot;        // slot frozen from here on
            state_q <= S_CHECK;
            busy_q  <= 1'b1;
          end
        end
        S_CHECK: begin
          // Occupancy is looked at only on this edge.
          if (parking_capacity[slot_q]) begin
            state_q        <= S_RELEASE;
            release_mask_q <= 8'd1 << slot_q;
            exit_ack_q     <= 1'b1;
          end else begin
            state_q    <= S_ERROR;
            exit_err_q <= 1'b1;
          end
        end
        S_RELEASE: begin
          state_q      <= S_GATE;
          gate_cnt_q   <= GATE_LOAD;
          gate_open_q  <= 1'b1;
          exit_count_q <= exit_count_d;
        end
        S_GATE: begin
          // Counter value equals remaining open cycles including this one.
          if (gate_cnt_q <= 4'd1) begin
            state_q     <= S_WAIT_LOW;
            gate_cnt_q  <= 4'd0;
            gate_open_q <= 1'b0;
          end else begin
            gate_cnt_q <= gate_cnt_q - 4'd1;
          end
        end
        S_ERROR: begin
          state_q <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          // A request still held from this transaction must not rearm.
          if (!exit_req) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          gate_cnt_q  <= 4'd0;
          gate_open_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign release_mask = release_mask_q;
  assign exit_ack     = exit_ack_q;
  assign exit_err     = exit_err_q;
  assign gate_open    = gate_open_q;
  assign busy         = busy_q;
  assign exit_count   = exit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_exit_park.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exit_park
//  Description : Scoreboard bench for exit_park. Stimulus pushes expected
//                responses; monitors pop and compare on exit_ack/exit_err
//                and check gate pulse widths and counter updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exit_park;

  logic       clk;
  logic       rst_n;
  logic       exit_req;
  logic [2:0] exit_slot;
  logic [7:0] parking_capacity;
  logic [7:0] release_mask, release_mask_1;
  logic       exit_ack, exit_ack_1;
  logic       exit_err, exit_err_1;
  logic       gate_open, gate_open_1;
  logic       busy, busy_1;
  logic [7:0] exit_count, exit_count_1;

  exit_park #(.GATE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .exit_req(exit_req), .exit_slot(exit_slot),
    .parking_capacity(parking_capacity), .release_mask(release_mask),
    .exit_ack(exit_ack), .exit_err(exit_err), .gate_open(gate_open),
    .busy(busy), .exit_count(exit_count)
  );

  // Single-cycle gate build shares the stimulus; only its gate width is judged.
  exit_park #(.GATE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .exit_req(exit_req), .exit_slot(exit_slot),
    .parking_capacity(parking_capacity), .release_mask(release_mask_1),
    .exit_ack(exit_ack_1), .exit_err(exit_err_1), .gate_open(gate_open_1),
    .busy(busy_1), .exit_count(exit_count_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] mask;
    logic       ack;
    logic       err;
    logic [7:0] cnt;     // exit_count expected once the transaction settles
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model_cnt = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitors ----------------
  int         gl  = 0;
  int         gl1 = 0;
  logic       cnt_pend = 1'b0;
  logic [7:0] cnt_exp  = 8'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      gl = 0; gl1 = 0; cnt_pend = 1'b0;
    end else begin
      check("mask_onehot0", {31'd0, $onehot0(release_mask)}, 32'd1);
      if (!exit_ack) check("mask_idle_zero", {24'd0, release_mask}, 32'd0);
      if (cnt_pend) begin
        check("exit_count", {24'd0, exit_count}, {24'd0, cnt_exp});
        cnt_pend = 1'b0;
      end
      if (exit_ack || exit_err) begin
        if (sb.size() == 0) begin
          check("unexpected_response", {30'd0, exit_ack, exit_err}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("release_mask", {24'd0, release_mask}, {24'd0, e.mask});
          check("exit_ack", {31'd0, exit_ack}, {31'd0, e.ack});
          check("exit_err", {31'd0, exit_err}, {31'd0, e.err});
          cnt_pend = 1'b1;
          cnt_exp  = e.cnt;
        end
      end
      if (gate_open) gl++;
      else if (gl != 0) begin
        check("gate_width", gl, 4);
        gl = 0;
      end
      if (gate_open_1) gl1++;
      else if (gl1 != 0) begin
        check("gate_width_g1", gl1, 1);
        gl1 = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 60 && busy; i++) tick();
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_resp();
    int i;
    for (i = 0; i < 20 && !(exit_ack || exit_err); i++) tick();
    if (!(exit_ack || exit_err)) check("resp_timeout", 32'd1, 32'd0);
  endtask

  task automatic expect_resp(input logic [7:0] mask, input logic ack, input logic err);
    exp_t e;
    if (ack) model_cnt = model_cnt + 8'd1;
    e.mask = mask; e.ack = ack; e.err = err; e.cnt = model_cnt;
    sb.push_back(e);
  endtask

  // One complete transaction: request held until the response, then dropped.
  task automatic run_exit(input logic [2:0] slot, input logic [7:0] cap,
                          input logic [7:0] mask, input logic ack, input logic err);
    wait_idle();
    expect_resp(mask, ack, err);
    exit_slot = slot; parking_capacity = cap; exit_req = 1'b1;
    wait_resp();
    exit_req = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mask"}, {24'd0, release_mask}, 32'd0);
    check({tag, "_ack"},  {31'd0, exit_ack}, 32'd0);
    check({tag, "_err"},  {31'd0, exit_err}, 32'd0);
    check({tag, "_gate"}, {31'd0, gate_open}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_count"}, {24'd0, exit_count}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_cnt = 8'd0;
    sb.delete();
    #1;
    check_reset_outputs("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; exit_req = 1'b0; exit_slot = 3'd0; parking_capacity = 8'd0;
    tick(); tick();
    check_reset_outputs("por");
    rst_n = 1'b1;
    tick();

    // Valid exit on slot 5: mask bit 5, latency two edges after acceptance.
    wait_idle();
    expect_resp(8'b0010_0000, 1'b1, 1'b0);
    exit_slot = 3'd5; parking_capacity = 8'b0010_0100; exit_req = 1'b1;
    tick();                                   // E0: accepted -> CHECK
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("no_ack_in_check", {31'd0, exit_ack}, 32'd0);
    tick();                                   // E1: RELEASE active
    check("ack_latency", {31'd0, exit_ack}, 32'd1);
    tick();                                   // E2: first gate cycle
    check("gate_after_release", {31'd0, gate_open}, 32'd1);
    exit_req = 1'b0;
    wait_idle();

    // Empty slot 3: error pulse, gate stays shut, count unchanged.
    wait_idle();
    expect_resp(8'h00, 1'b0, 1'b1);
    exit_slot = 3'd3; parking_capacity = 8'b0010_0100; exit_req = 1'b1;
    wait_resp();
    exit_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("gate_shut_on_err", {31'd0, gate_open}, 32'd0);
    end
    check("count_after_err", {24'd0, exit_count}, 32'd1);
    wait_idle();

    // Held request for 20 cycles: exactly one service; then rearm on slot 2.
    expect_resp(8'b0000_0100, 1'b1, 1'b0);
    exit_slot = 3'd2; parking_capacity = 8'b0010_0100; exit_req = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("held_still_busy", {31'd0, busy}, 32'd1);
    exit_req = 1'b0;
    tick();
    expect_resp(8'b0000_0100, 1'b1, 1'b0);
    exit_req = 1'b1;
    wait_resp();
    exit_req = 1'b0;
    wait_idle();

    // In-flight changes: slot changes in CHECK, occupancy cleared afterwards,
    // and a new request raised during GATE is ignored.
    expect_resp(8'b0010_0000, 1'b1, 1'b0);
    exit_slot = 3'd5; parking_capacity = 8'b0010_0100; exit_req = 1'b1;
    tick();                                   // in CHECK
    exit_slot = 3'd1;
    tick();                                   // in RELEASE
    parking_capacity = 8'b0000_0100;
    exit_req = 1'b0;
    tick();                                   // GATE
    exit_slot = 3'd2; exit_req = 1'b1;
    tick(); tick();
    exit_req = 1'b0;
    wait_idle();
    for (int k = 0; k < 4; k++) tick();

    // Boundary slots with full and empty occupancy.
    run_exit(3'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
    run_exit(3'd7, 8'hFF, 8'h80, 1'b1, 1'b0);
    run_exit(3'd7, 8'h00, 8'h00, 1'b0, 1'b1);
    run_exit(3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("count_before_reset", {24'd0, exit_count}, 32'd6);

    // Reset in the middle of GATE aborts everything asynchronously.
    wait_idle();
    expect_resp(8'h80, 1'b1, 1'b0);
    exit_slot = 3'd7; parking_capacity = 8'h80; exit_req = 1'b1;
    wait_resp();
    exit_req = 1'b0;
    tick(); tick();
    check("gate_before_reset", {31'd0, gate_open}, 32'd1);
    do_reset();
    run_exit(3'd0, 8'h01, 8'h01, 1'b1, 1'b0);
    check("count_after_reset", {24'd0, exit_count}, 32'd1);

    // Wrap: 256 successful exits from zero bring the counter back to zero.
    do_reset();
    for (int n = 0; n < 256; n++) run_exit(3'd0, 8'hFF, 8'h01, 1'b1, 1'b0);
    tick(); tick();
    check("count_wrap", {24'd0, exit_count}, 32'd0);

    tick(); tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so a stuck design can never hang the run.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
